// File: rtl/hardtanh_pkg.sv
// Shared bound semantics for the forward hardtanh and its backward companion.
package hardtanh_pkg;

  // Bit pattern driven for every element whose saved input sat on or beyond a clamp bound.
  localparam logic OutOfRangeBit = 1'b0;

  // True strictly inside (min_val, max_val); the bounds themselves are clamped.
  function automatic logic in_range(input int x, input int min_val, input int max_val);
    return (x > min_val) && (x < max_val);
  endfunction

endpackage

// File: rtl/hardtanh_skid_buffer.sv
// Two-entry valid/ready register stage: a main output register plus one skid entry.
module hardtanh_skid_buffer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [N-1:0][W-1:0] in_data_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [N-1:0][W-1:0] out_data_o,
  output logic                out_last_o
);

  logic                main_valid_q;
  logic [N-1:0][W-1:0] main_data_q;
  logic                main_last_q;
  logic                skid_valid_q;
  logic [N-1:0][W-1:0] skid_data_q;
  logic                skid_last_q;
  logic                pop;

  assign pop         = main_valid_q & out_ready_i;
  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign out_last_o  = main_last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else if (pop && skid_valid_q) begin
      // in_ready_o is low whenever skid is full, so no input can arrive here.
      main_data_q  <= skid_data_q;
      main_last_q  <= skid_last_q;
      skid_valid_q <= 1'b0;
    end else if (in_valid_i && (!main_valid_q || pop)) begin
      main_valid_q <= 1'b1;
      main_data_q  <= in_data_i;
      main_last_q  <= in_last_i;
    end else if (in_valid_i && !skid_valid_q) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= in_data_i;
      skid_last_q  <= in_last_i;
    end else if (pop) begin
      main_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hardtanh_backward.sv
// Hardtanh backward pass: joins saved x with upstream dy and emits dx, zeroed at/beyond the bounds.
module hardtanh_backward
  import hardtanh_pkg::*;
#(
  parameter int          MAX_VAL                      = 127,
  parameter int          MIN_VAL                      = -128,
  parameter int unsigned DATA_IN_0_PRECISION_0        = 8,
  parameter int unsigned DATA_IN_1_PRECISION_0        = 8,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_0  = 8,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_0  = 4,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1  = 1,
  parameter int unsigned DATA_OUT_0_PRECISION_0       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_IN_1_PRECISION_0-1:0]  data_in_1,
  input  logic                              data_in_1_valid,
  output logic                              data_in_1_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1-1:0]
               [DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                              data_out_0_last,
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int unsigned N     = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
  localparam int unsigned BEATS = DATA_IN_0_TENSOR_SIZE_DIM_0 / DATA_IN_0_PARALLELISM_DIM_0;
  localparam int unsigned CntW  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned IW    = DATA_IN_1_PRECISION_0;
  localparam int unsigned OW    = DATA_OUT_0_PRECISION_0;

  logic                 accept;
  logic                 fire;
  logic                 beat_last;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [N-1:0][OW-1:0] dy_rs;
  logic [N-1:0][OW-1:0] dx;

  // Readies are held low during reset so nothing is consumed before the first clean cycle.
  assign data_in_0_ready = accept & data_in_1_valid & ~rst;
  assign data_in_1_ready = accept & data_in_0_valid & ~rst;
  assign fire            = accept & data_in_0_valid & data_in_1_valid & ~rst;

  // Resize dy: sign-extend when widening, keep the low bits when narrowing.
  for (genvar i = 0; i < N; i++) begin : g_elem
    for (genvar b = 0; b < OW; b++) begin : g_bit
      if (b < IW) begin : g_copy
        assign dy_rs[i][b] = data_in_1[i][b];
      end else begin : g_sext
        assign dy_rs[i][b] = data_in_1[i][IW-1];
      end
    end
  end

  always_comb begin
    dx = '0;
    for (int i = 0; i < N; i++) begin
      dx[i] = in_range(int'($signed(data_in_0[i])), MIN_VAL, MAX_VAL) ? dy_rs[i]
                                                                       : {OW{OutOfRangeBit}};
    end
  end

  assign beat_last = (cnt_q == CntW'(BEATS - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (fire) begin
      cnt_d = beat_last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  hardtanh_skid_buffer #(
    .N (N),
    .W (OW)
  ) u_out_stage (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (fire),
    .in_ready_o  (accept),
    .in_data_i   (dx),
    .in_last_i   (beat_last),
    .out_valid_o (data_out_0_valid),
    .out_ready_i (data_out_0_ready),
    .out_data_o  (data_out_0),
    .out_last_o  (data_out_0_last)
  );

endmodule
